pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 15, giving the maximum number of consecutive memory-wait cycles before a timeout.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.

Ports:
REQ-003 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ID_EX_MemRead  in  1  the instruction in EX is a load.
REQ-006 ID_EX_Rt  in  5  the load destination register.
REQ-007 IF_ID_Rs, IF_ID_Rt  in  5 each  the source registers of the instruction in ID.
REQ-008 branch_taken  in  1  a branch resolved taken in ID this cycle.
REQ-009 mem_req  in  1  the MEM stage is accessing data memory this cycle.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 PCWrite  out  1  PC update enable.
REQ-012 IF_ID_Write  out  1  IF/ID register load enable.
REQ-013 IF_ID_Flush  out  1  IF/ID register clear to NOP.
REQ-014 ID_EX_Bubble  out  1  load a NOP into ID/EX.
REQ-015 ID_EX_Hold, EX_MEM_Hold  out  1 each  freeze the ID/EX and EX/MEM registers.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  statistics counters.
REQ-017 mem_timeout  out  1  sticky memory-timeout error flag.

Function
REQ-018 The FSM SHALL have three states: RUN, MEM_WAIT and ERR, encoded in 2 bits.
REQ-019 Control outputs SHALL be combinational from the state and the inputs (Mealy); the counters and mem_timeout SHALL be registered.
REQ-020 Idle output values SHALL be PCWrite=1 and IF_ID_Write=1, with IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold and EX_MEM_Hold all 0.
REQ-021 Load-use hazard (lu) SHALL be ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt).
REQ-022 Memory wait (mw) SHALL be mem_req && !mem_ready.
REQ-023 In RUN, the priority SHALL be mw > branch_taken > lu.
REQ-024 RUN with mw SHALL drive PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1 and EX_MEM_Hold=1 in the same cycle, and the next state SHALL be MEM_WAIT with wait_cnt=1.
REQ-025 RUN with branch_taken (and no mw) SHALL drive IF_ID_Flush=1 with PCWrite=1 and no bubble, even if lu is also true.
REQ-026 RUN with lu only SHALL drive PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 for exactly one cycle; the state SHALL stay RUN, because the bubble clears ID_EX_MemRead.
REQ-027 In MEM_WAIT with mem_ready=0, the freeze outputs of REQ-024 SHALL stay asserted and wait_cnt SHALL increment.
REQ-028 If wait_cnt==MEM_WAIT_MAX and mem_ready=0, the next state SHALL be ERR.
REQ-029 In MEM_WAIT with mem_ready=1, the outputs SHALL be idle in that cycle, the next state SHALL be RUN and wait_cnt SHALL clear.
- branch_taken and lu SHALL be ignored during this exit cycle.
REQ-030 branch_taken and lu SHALL be ignored in MEM_WAIT; the frozen pipeline keeps them stable, so they are evaluated on return to RUN.
REQ-031 ERR SHALL drive the freeze outputs of REQ-024 and mem_timeout=1 permanently, and SHALL be left only by rst.
REQ-032 stall_cnt SHALL increment on every cycle with PCWrite==0; flush_cnt SHALL increment on every cycle with IF_ID_Flush==1.
- Both SHALL saturate at all-ones (no wrap).
REQ-033 wait_cnt SHALL be ceil(log2(MEM_WAIT_MAX+1)) bits wide.

Reset
REQ-034 While rst=1, the control outputs SHALL be forced to idle values regardless of the other inputs.
REQ-035 On any clock edge with rst=1, the state SHALL become RUN and wait_cnt, stall_cnt, flush_cnt and mem_timeout SHALL become 0, including in the middle of MEM_WAIT or ERR.

Structure
REQ-036 The state encoding and the idle-value constants SHALL live in the shared package pipe_ctrl_pkg.
REQ-037 The load-use comparator SHALL be the sub-module hazard_detect; the FSM, wait counter and statistics SHALL stay in the top module.

Verification
REQ-038 Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> exactly one cycle of PCWrite=0 and ID_EX_Bubble=1, stall_cnt=1.
REQ-039 r0 case: ID_EX_Rt=0, IF_ID_Rt=0, ID_EX_MemRead=1 -> no stall, outputs idle.
REQ-040 Branch and load-use together: branch_taken=1 in the same cycle as a load-use hazard -> IF_ID_Flush=1, PCWrite=1, ID_EX_Bubble=0, flush_cnt=1.
REQ-041 Memory wait: mem_req=1 with mem_ready low for 3 cycles then high -> 3 frozen cycles, release on the ready cycle, stall_cnt=3, state RUN.
REQ-042 Timeout: mem_ready held low for 16+ cycles with MEM_WAIT_MAX=15 -> ERR and mem_timeout=1 stay sticky; rst pulse -> RUN with all counters at 0.
REQ-043 Saturation: CNT_W=4 with 20 load-use stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller:
//             FSM state encoding and the control-output bundles (idle,
//             freeze, flush, load-use stall).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

   // Bit order matches the output ports of the top module.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic id_ex_hold;
      logic ex_mem_hold;
   } ctrl_t;

   localparam ctrl_t C_CTRL_IDLE   = 6'b11_0000;
   // Whole front end frozen while data memory is busy (or after a timeout).
   localparam ctrl_t C_CTRL_FREEZE = 6'b00_0011;
   // Taken branch: squash the wrong-path fetch, PC keeps moving.
   localparam ctrl_t C_CTRL_FLUSH  = 6'b11_1000;
   // Load-use: hold PC and IF/ID, inject a NOP into ID/EX.
   localparam ctrl_t C_CTRL_STALL  = 6'b00_0100;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Purpose  : Load-use comparator. Flags when the load in EX writes a
//             register that the instruction in ID reads. r0 never hazards.
//  Ports    : id_ex_mem_read  in  EX instruction is a load
//             id_ex_rt        in  load destination register
//             if_id_rs/rt     in  ID source registers
//             load_use        out hazard present
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect (
   input  logic       id_ex_mem_read,
   input  logic [4:0] id_ex_rt,
   input  logic [4:0] if_id_rs,
   input  logic [4:0] if_id_rt,
   output logic       load_use
);
   import pipe_ctrl_pkg::*;

   assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard control for a 5-stage pipeline. Handles memory-wait
//             freezes (with timeout), taken-branch flushes and load-use
//             stalls, and keeps saturating stall/flush statistics.
//  Ports    : clk, rst                     clock, sync active-high reset
//             ID_EX_MemRead, ID_EX_Rt      load in EX and its destination
//             IF_ID_Rs, IF_ID_Rt           ID source registers
//             branch_taken                 branch resolved taken in ID
//             mem_req, mem_ready           data-memory handshake
//             PCWrite .. EX_MEM_Hold       pipeline control (combinational)
//             stall_cnt, flush_cnt         statistics (registered)
//             mem_timeout                  sticky timeout flag (registered)
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rt,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             ID_EX_Hold,
   output logic             EX_MEM_Hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);
   import pipe_ctrl_pkg::*;

   localparam int                C_WAIT_W   = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(MEM_WAIT_MAX);

   state_t              r_state, w_next_state;
   logic [C_WAIT_W-1:0] r_wait_cnt, w_next_wait;
   logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;
   logic                r_timeout, w_next_timeout;
   logic                w_lu, w_mw;
   ctrl_t               w_ctrl;

   hazard_detect u_hazard_detect (
      .id_ex_mem_read (ID_EX_MemRead),
      .id_ex_rt       (ID_EX_Rt),
      .if_id_rs       (IF_ID_Rs),
      .if_id_rt       (IF_ID_Rt),
      .load_use       (w_lu)
   );

   assign w_mw = mem_req && !mem_ready;

   // Next-state and Mealy outputs.
   always_comb begin
      w_ctrl         = C_CTRL_IDLE;
      w_next_state   = r_state;
      w_next_wait    = r_wait_cnt;
      w_next_timeout = r_timeout;
      case (r_state)
         ST_RUN: begin
            if (w_mw) begin
               w_ctrl       = C_CTRL_FREEZE;
               w_next_state = ST_MEM_WAIT;
               w_next_wait  = C_WAIT_W'(1);
            end else if (branch_taken) begin
               w_ctrl = C_CTRL_FLUSH;
            end else if (w_lu) begin
               // Stay in RUN: the bubble clears ID_EX_MemRead next cycle.
               w_ctrl = C_CTRL_STALL;
            end
         end
         ST_MEM_WAIT: begin
            // Branch/load-use are held stable by the freeze and are
            // evaluated once the FSM is back in RUN.
            if (mem_ready) begin
               w_next_state = ST_RUN;
               w_next_wait  = '0;
            end else begin
               w_ctrl = C_CTRL_FREEZE;
               if (r_wait_cnt == C_WAIT_MAX) begin
                  w_next_state   = ST_ERR;
                  w_next_timeout = 1'b1;
               end else begin
                  w_next_wait = r_wait_cnt + C_WAIT_W'(1);
               end
            end
         end
         ST_ERR: begin
            w_ctrl         = C_CTRL_FREEZE;
            w_next_timeout = 1'b1;
         end
         default: begin
            w_next_state = ST_RUN;
            w_next_wait  = '0;
         end
      endcase
      if (rst) begin
         w_ctrl = C_CTRL_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait;
         r_timeout  <= w_next_timeout;
         if (!w_ctrl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_ctrl.if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign PCWrite      = w_ctrl.pc_write;
   assign IF_ID_Write  = w_ctrl.if_id_write;
   assign IF_ID_Flush  = w_ctrl.if_id_flush;
   assign ID_EX_Bubble = w_ctrl.id_ex_bubble;
   assign ID_EX_Hold   = w_ctrl.id_ex_hold;
   assign EX_MEM_Hold  = w_ctrl.ex_mem_hold;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;
   assign mem_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. Two instances
//             share stimulus: default widths, and CNT_W=4 for saturation.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int C_MAX = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
   logic       branch_taken, mem_req, mem_ready;

   logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold;
   logic [15:0] stall_cnt, flush_cnt;
   logic        mem_timeout;
   logic        s_PCWrite, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_ID_EX_Hold, s_EX_MEM_Hold;
   logic [3:0]  s_stall_cnt, s_flush_cnt;
   logic        s_mem_timeout;

   pipeline_hazard_ctrl #(.MEM_WAIT_MAX(C_MAX), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .PCWrite(PCWrite),
      .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
      .ID_EX_Hold(ID_EX_Hold), .EX_MEM_Hold(EX_MEM_Hold), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   pipeline_hazard_ctrl #(.MEM_WAIT_MAX(C_MAX), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .PCWrite(s_PCWrite),
      .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Bubble(s_ID_EX_Bubble),
      .ID_EX_Hold(s_ID_EX_Hold), .EX_MEM_Hold(s_EX_MEM_Hold), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt), .mem_timeout(s_mem_timeout)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------ checker
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------- model
   localparam int M_RUN = 0, M_WAIT = 1, M_ERR = 2;
   // Control bundle order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold
   localparam logic [5:0] E_IDLE = 6'b110000, E_FRZ = 6'b000011,
                          E_FLS  = 6'b111000, E_STL = 6'b000100;

   int m_state = M_RUN, m_wait = 0;
   int m_st16 = 0, m_fl16 = 0, m_st4 = 0, m_fl4 = 0;
   bit m_tmo = 1'b0;
   bit m_valid = 1'b0;   // counters are unknown until the first reset edge

   typedef struct {
      logic [5:0] ctrl;
      int         st16, fl16, st4, fl4;
      bit         tmo;
      bit         valid;
   } exp_t;
   exp_t sb_q[$];

   task automatic run_cycle(input logic r, input logic mr, input logic [4:0] ert,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic br, input logic mq, input logic rdy);
      exp_t e, g;
      bit   lu, mw;
      logic [5:0] c;
      rst = r; ID_EX_MemRead = mr; ID_EX_Rt = ert; IF_ID_Rs = rs; IF_ID_Rt = rt;
      branch_taken = br; mem_req = mq; mem_ready = rdy;
      lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
      mw = mq && !rdy;
      c  = E_IDLE;
      if (!r) begin
         if (m_state == M_RUN) begin
            if (mw)      c = E_FRZ;
            else if (br) c = E_FLS;
            else if (lu) c = E_STL;
         end else if (m_state == M_WAIT) begin
            c = rdy ? E_IDLE : E_FRZ;
         end else begin
            c = E_FRZ;
         end
      end
      e.ctrl = c; e.st16 = m_st16; e.fl16 = m_fl16; e.st4 = m_st4; e.fl4 = m_fl4;
      e.tmo = m_tmo; e.valid = m_valid;
      sb_q.push_back(e);
      #2;
      g = sb_q.pop_front();
      check_value("ctrl", {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Hold}, {26'd0, g.ctrl});
      check_value("ctrl_w4", {26'd0, s_PCWrite, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_ID_EX_Hold, s_EX_MEM_Hold}, {26'd0, g.ctrl});
      if (g.valid) begin
         check_value("stall_cnt", {16'd0, stall_cnt}, g.st16);
         check_value("flush_cnt", {16'd0, flush_cnt}, g.fl16);
         check_value("stall_cnt_w4", {28'd0, s_stall_cnt}, g.st4);
         check_value("flush_cnt_w4", {28'd0, s_flush_cnt}, g.fl4);
         check_value("mem_timeout", {31'd0, mem_timeout}, {31'd0, g.tmo});
      end
      @(posedge clk);
      #1;
      if (r) begin
         m_state = M_RUN; m_wait = 0; m_tmo = 1'b0; m_valid = 1'b1;
         m_st16 = 0; m_fl16 = 0; m_st4 = 0; m_fl4 = 0;
      end else begin
         if (!c[5]) begin
            if (m_st16 < 65535) m_st16++;
            if (m_st4 < 15)     m_st4++;
         end
         if (c[3]) begin
            if (m_fl16 < 65535) m_fl16++;
            if (m_fl4 < 15)     m_fl4++;
         end
         case (m_state)
            M_RUN:  if (mw) begin m_state = M_WAIT; m_wait = 1; end
            M_WAIT: begin
               if (rdy) begin m_state = M_RUN; m_wait = 0; end
               else if (m_wait == C_MAX) begin m_state = M_ERR; m_tmo = 1'b1; end
               else m_wait++;
            end
            default: m_state = M_ERR;
         endcase
      end
   endtask

   task automatic idle_cycle(input logic r);
      run_cycle(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      #1;
      // Reset with hostile inputs: outputs must read idle.
      run_cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0);
      idle_cycle(1'b0);

      // Load-use on Rs: one stall cycle, then the bubble clears MemRead.
      run_cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b0);
      check_value("lu_stall_total", {16'd0, stall_cnt}, 32'd1);

      // r0 never hazards.
      run_cycle(1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      // Load-use on Rt.
      run_cycle(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0);

      // Branch wins over load-use.
      idle_cycle(1'b1);
      run_cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
      idle_cycle(1'b0);
      check_value("br_flush_total", {16'd0, flush_cnt}, 32'd1);
      check_value("br_stall_total", {16'd0, stall_cnt}, 32'd0);

      // Memory wait: 3 not-ready cycles, then ready; branch/lu ignored meanwhile.
      idle_cycle(1'b1);
      run_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
      run_cycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1);
      idle_cycle(1'b0);
      check_value("mw_stall_total", {16'd0, stall_cnt}, 32'd3);

      // Random traffic, memory mostly ready.
      for (int i = 0; i < 60; i++) begin
         run_cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0));
      end

      // Timeout: ready held low long enough to reach ERR; ERR is sticky.
      idle_cycle(1'b1);
      for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)  run_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      check_value("err_sticky_tmo", {31'd0, mem_timeout}, 32'd1);
      check_value("err_sticky_pcw", {31'd0, PCWrite}, 32'd0);
      // Reset pulse leaves ERR.
      idle_cycle(1'b1);
      check_value("rst_stall", {16'd0, stall_cnt}, 32'd0);
      check_value("rst_tmo", {31'd0, mem_timeout}, 32'd0);
      idle_cycle(1'b0);

      // Saturation: 20 consecutive load-use stalls.
      for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b0);
      check_value("sat_w4", {28'd0, s_stall_cnt}, 32'd15);
      check_value("sat_w16", {16'd0, stall_cnt}, 32'd20);

      if (sb_q.size() != 0) check_value("sb_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
